// File: rtl/eject_buffer_pkg.sv
// Shared flit layout, local coordinate defaults and direction codes for the eject buffer.
package eject_buffer_pkg;

  localparam int unsigned FLIT_W  = 11;
  localparam int unsigned GS_HI   = 10;
  localparam int unsigned GS_LO   = 9;
  localparam int unsigned DIR_HI  = 8;
  localparam int unsigned DIR_LO  = 6;
  localparam int unsigned ADDR_HI = 5;
  localparam int unsigned ADDR_LO = 0;
  localparam int unsigned ROW_HI  = 5;
  localparam int unsigned ROW_LO  = 3;
  localparam int unsigned COL_HI  = 2;
  localparam int unsigned COL_LO  = 0;

  localparam logic [2:0] LOCAL_ROW_DEF = 3'b100;
  localparam logic [2:0] LOCAL_COL_DEF = 3'b100;

  typedef enum logic [2:0] {
    DIR_EAST  = 3'b000,
    DIR_WEST  = 3'b001,
    DIR_NORTH = 3'b010,
    DIR_SOUTH = 3'b011,
    DIR_LOCAL = 3'b100
  } dir_e;

  typedef struct packed {
    logic [1:0] gs;
    dir_e       dir;
    logic [2:0] row;
    logic [2:0] col;
  } flit_t;

  // True when a 6-bit address names the given node.
  function automatic logic addr_match(input logic [5:0] addr,
                                      input logic [2:0] row,
                                      input logic [2:0] col);
    return (addr[ROW_HI:ROW_LO] == row) && (addr[COL_HI:COL_LO] == col);
  endfunction

endpackage

// File: rtl/eject_buffer_if.sv
// Ejector-to-buffer and buffer-to-PE handshake bundle.
interface eject_buffer_if #(
  parameter int unsigned FLIT_W = eject_buffer_pkg::FLIT_W
) ();

  logic              ej_valid;
  logic [FLIT_W-1:0] ej_flit;
  logic              ej_full;
  logic              pe_valid;
  logic [FLIT_W-1:0] pe_flit;
  logic              pe_ready;

  // Buffer side.
  modport slave (
    input  ej_valid, ej_flit, pe_ready,
    output ej_full, pe_valid, pe_flit
  );

  // Ejector/PE side.
  modport master (
    output ej_valid, ej_flit, pe_ready,
    input  ej_full, pe_valid, pe_flit
  );

endinterface

// File: rtl/eject_buffer_flit_fifo.sv
// First-word fall-through flit FIFO; head reads as zero while empty.
module flit_fifo #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned FLIT_W = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [FLIT_W-1:0]        wdata,
  output logic [FLIT_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign valid   = (count != '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & valid;
  assign rdata   = valid ? mem[rd_ptr] : '0;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/eject_buffer.sv
// Local-node eject buffer: address check, sticky error flags and accept counter around a flit FIFO.
module eject_buffer import eject_buffer_pkg::*; #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned FLIT_W    = eject_buffer_pkg::FLIT_W,
  parameter logic [2:0]  LOCAL_ROW = LOCAL_ROW_DEF,
  parameter logic [2:0]  LOCAL_COL = LOCAL_COL_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  eject_buffer_if.slave          ej,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [15:0]            ej_count,
  output logic                   overflow,
  output logic                   misroute
);

  logic              local_hit;
  logic              fifo_full;
  logic              fifo_valid;
  logic              push;
  logic              pop;
  logic [FLIT_W-1:0] head;

  assign local_hit = addr_match(ej.ej_flit[ADDR_HI:ADDR_LO], LOCAL_ROW, LOCAL_COL);
  // Full is judged on registered state, so a same-cycle pop never frees a slot for a push.
  assign push      = ej.ej_valid & local_hit & ~fifo_full;
  assign pop       = fifo_valid & ej.pe_ready;

  flit_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (ej.ej_flit),
    .rdata (head),
    .count (occupancy),
    .full  (fifo_full),
    .valid (fifo_valid)
  );

  assign ej.ej_full  = fifo_full;
  assign ej.pe_valid = fifo_valid;
  assign ej.pe_flit  = head;

  // Misroute wins over overflow when a non-local flit arrives while full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ej_count <= '0;
      overflow <= 1'b0;
      misroute <= 1'b0;
    end else begin
      if (push && (ej_count != 16'hFFFF)) ej_count <= ej_count + 16'd1;
      if (ej.ej_valid && !local_hit) misroute <= 1'b1;
      if (ej.ej_valid && local_hit && fifo_full) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_eject_buffer.sv
// Scoreboard bench for eject_buffer: expected flits queued on accepted push, compared on pop.
module tb_eject_buffer;
  import eject_buffer_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [2:0]  occupancy;
  logic [15:0] ej_count;
  logic        overflow;
  logic        misroute;

  eject_buffer_if #(.FLIT_W(11)) bus ();

  eject_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ej        (bus),
    .occupancy (occupancy),
    .ej_count  (ej_count),
    .overflow  (overflow),
    .misroute  (misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0] sb_q[$];
  int          m_cnt;
  logic        m_ovf;
  logic        m_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] mk(input int k);
    flit_t f;
    f.gs  = 2'(k);
    f.dir = dir_e'(3'(k >> 2));
    f.row = LOCAL_ROW_DEF;
    f.col = LOCAL_COL_DEF;
    return f;
  endfunction

  task automatic check_state(input string tag);
    logic [10:0] hd;
    hd = (sb_q.size() != 0) ? sb_q[0] : 11'd0;
    check({tag, ".occ"},      32'(occupancy),    32'(sb_q.size()));
    check({tag, ".full"},     32'(bus.ej_full),  32'(sb_q.size() == DEPTH));
    check({tag, ".pe_valid"}, 32'(bus.pe_valid), 32'(sb_q.size() != 0));
    check({tag, ".pe_flit"},  32'(bus.pe_flit),  32'(hd));
    check({tag, ".ej_count"}, 32'(ej_count),     32'(m_cnt));
    check({tag, ".overflow"}, 32'(overflow),     32'(m_ovf));
    check({tag, ".misroute"}, 32'(misroute),     32'(m_mis));
  endtask

  // One clock cycle of stimulus; inputs applied 1 time unit after the previous edge.
  task automatic step(input string tag, input logic v, input logic [10:0] f, input logic r);
    logic is_local;
    logic do_push;
    logic do_pop;
    bus.ej_valid = v;
    bus.ej_flit  = f;
    bus.pe_ready = r;
    #1;
    do_pop  = r && (sb_q.size() != 0);
    do_push = 1'b0;
    if (v) begin
      is_local = (f[5:0] == {LOCAL_ROW_DEF, LOCAL_COL_DEF});
      if (!is_local)                 m_mis = 1'b1;
      else if (sb_q.size() == DEPTH) m_ovf = 1'b1;
      else                           do_push = 1'b1;
    end
    if (do_pop) check({tag, ".pop"}, 32'(bus.pe_flit), 32'(sb_q.pop_front()));
    if (do_push) begin
      sb_q.push_back(f);
      if (m_cnt != 16'hFFFF) m_cnt++;
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  // Reset cycle with a local push and a pop offered, both to be ignored.
  task automatic do_reset(input string tag);
    rst_n        = 1'b0;
    bus.ej_valid = 1'b1;
    bus.ej_flit  = mk(7);
    bus.pe_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.ej_valid = 1'b0;
    bus.pe_ready = 1'b0;
    sb_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_mis = 1'b0;
    check_state(tag);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ej_valid = 1'b0;
    bus.ej_flit  = '0;
    bus.pe_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("rst0");

    // Single push, head visible the next cycle.
    step("first", 1'b1, 11'b00_100_100100, 1'b0);
    check("first.head_const", 32'(bus.pe_flit), 32'h124);

    // Fill to full, then one more push overflows.
    for (int i = 1; i < 4; i++) step("fill", 1'b1, mk(i), 1'b0);
    step("ovf", 1'b1, mk(9), 1'b0);
    check("ovf.count_const", 32'(ej_count), 32'd4);

    // Pop and push together while full: only the pop happens.
    step("full_pp", 1'b1, mk(10), 1'b1);
    check("full_pp.occ_const", 32'(occupancy), 32'd3);

    // Down to two, then steady push+pop across pointer wrap.
    step("drain1", 1'b0, 11'bx, 1'b1);
    for (int i = 0; i < 10; i++) step("steady", 1'b1, mk(11 + i), 1'b1);

    // Non-local address dropped.
    step("misr", 1'b1, 11'b00_000_101100, 1'b0);

    // Misroute takes precedence over overflow when full.
    do_reset("rst1");
    for (int i = 0; i < 4; i++) step("fill2", 1'b1, mk(20 + i), 1'b0);
    step("prec", 1'b1, 11'b01_010_000000, 1'b0);
    check("prec.ovf_const", 32'(overflow), 32'd0);

    // Reset with three stored, then a fresh push is the only head.
    do_reset("rst2");
    for (int i = 0; i < 3; i++) step("fill3", 1'b1, mk(24 + i), 1'b0);
    do_reset("rst3");
    step("post_rst", 1'b1, mk(30), 1'b0);
    step("pop_last", 1'b0, 11'bx, 1'b1);
    step("ready_empty", 1'b0, 11'bx, 1'b1);

    // Randomised traffic with a mostly-local address mix.
    for (int i = 0; i < 300; i++) begin
      logic [10:0] f;
      f = mk(int'($urandom_range(0, 31)));
      if ($urandom_range(0, 9) == 0) f[5:0] = 6'($urandom_range(0, 63));
      step("rand", 1'($urandom_range(0, 1)), f, 1'($urandom_range(0, 2) != 0));
    end

    // Drain whatever is left, bounded.
    for (int i = 0; i < 2 * DEPTH && sb_q.size() != 0; i++) step("drain", 1'b0, 11'bx, 1'b1);
    check("drain.empty", 32'(bus.pe_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
